// File: rtl/ff_check_pkg.sv
// Shared types and defaults for the serial flip-flop stream checker.
package ff_check_pkg;

   localparam int unsigned LCG_W = 32;

   localparam logic [LCG_W-1:0] DEF_SEED = 32'd3;
   localparam logic [LCG_W-1:0] DEF_MULT = 32'd7;
   localparam logic [LCG_W-1:0] DEF_DIV  = 32'd11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } chk_state_t;

   // Stimulus bit derived from an LCG value: LSB of the truncated quotient.
   function automatic logic lcg_bit(input logic [LCG_W-1:0] v, input logic [LCG_W-1:0] div);
      logic [LCG_W-1:0] quo;
      quo = v / div;
      return quo[0];
   endfunction

endpackage

// File: rtl/ff_lcg_gen.sv
// Multiplicative LCG regenerating the flip-flop d stimulus stream.
module ff_lcg_gen
   import ff_check_pkg::*;
#(
   parameter logic [LCG_W-1:0] SEED = DEF_SEED,
   parameter logic [LCG_W-1:0] MULT = DEF_MULT,
   parameter logic [LCG_W-1:0] DIV  = DEF_DIV
)(
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic advance,
   output logic d_exp
);

   logic [LCG_W-1:0] cnt;
   logic [LCG_W-1:0] cnt_nxt;

   always_comb begin
      cnt_nxt = cnt;
      if (load)
         cnt_nxt = SEED * MULT;
      else if (advance)
         cnt_nxt = cnt * MULT;
   end

   // d_exp only moves with the LCG so it stays 0 until the first load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= SEED;
         d_exp <= 1'b0;
      end else if (load || advance) begin
         cnt   <= cnt_nxt;
         d_exp <= lcg_bit(cnt_nxt, DIV);
      end
   end

endmodule

// File: rtl/ff_stream_checker.sv
// Compares sampled q of a flip-flop/latch under test against the regenerated d stream.
// Optional FF_CHECKER_ERR_LOG_EN: capture bit index of the first mismatch in first_err_idx.
module ff_stream_checker
   import ff_check_pkg::*;
#(
   parameter logic [LCG_W-1:0] SEED     = DEF_SEED,
   parameter logic [LCG_W-1:0] MULT     = DEF_MULT,
   parameter logic [LCG_W-1:0] DIV      = DEF_DIV,
   parameter int unsigned      NUM_BITS = 64,
   parameter int unsigned      MAX_ERR  = 4,
   parameter int unsigned      ERR_W    = 16
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             q_valid,
   input  logic             q_in,
   output logic             d_exp,
   output logic [1:0]       state,
   output logic [31:0]      bit_cnt,
   output logic [ERR_W-1:0] err_cnt,
   output logic             pass,
   output logic             fail,
   output logic [31:0]      first_err_idx
);

   localparam logic [ERR_W-1:0] MAX_ERR_V = ERR_W'(MAX_ERR);

   chk_state_t       st;
   logic             exp_q;
   logic             start_ok;
   logic             prime_go;
   logic             check_go;
   logic             mism;
   logic             last_bit;
   logic             hit_max;
   logic [ERR_W-1:0] err_nxt;
   logic [31:0]      bit_nxt;

   assign start_ok = start && (st == IDLE || st == DONE);
   assign prime_go = q_valid && (st == PRIME);
   assign check_go = q_valid && (st == CHECK);
   assign mism     = check_go && (q_in != exp_q);
   assign err_nxt  = (mism && (err_cnt != '1)) ? err_cnt + 1'b1 : err_cnt;
   assign bit_nxt  = bit_cnt + 32'd1;
   assign last_bit = (bit_nxt == NUM_BITS);
   assign hit_max  = (MAX_ERR != 0) && mism && (err_nxt == MAX_ERR_V);
   assign state    = st;

   ff_lcg_gen #(
      .SEED (SEED),
      .MULT (MULT),
      .DIV  (DIV)
   ) u_lcg (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (start_ok),
      .advance (prime_go || check_go),
      .d_exp   (d_exp)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st      <= IDLE;
         exp_q   <= 1'b0;
         bit_cnt <= '0;
         err_cnt <= '0;
         pass    <= 1'b0;
         fail    <= 1'b0;
      end else begin
         case (st)
            IDLE, DONE: begin
               if (start) begin
                  bit_cnt <= '0;
                  err_cnt <= '0;
                  pass    <= 1'b0;
                  fail    <= 1'b0;
                  st      <= PRIME;
               end
            end
            PRIME: begin
               if (q_valid) begin
                  exp_q <= d_exp;
                  st    <= CHECK;
               end
            end
            CHECK: begin
               // exp_q lags d_exp by one strobe, matching the DUT's own register delay.
               if (q_valid) begin
                  exp_q   <= d_exp;
                  bit_cnt <= bit_nxt;
                  err_cnt <= err_nxt;
                  if (last_bit || hit_max) begin
                     st   <= DONE;
                     pass <= (err_nxt == '0);
                     fail <= (err_nxt != '0);
                  end
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

`ifdef FF_CHECKER_ERR_LOG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         first_err_idx <= '0;
      else if (start_ok)
         first_err_idx <= '0;
      else if (mism && (err_cnt == '0))
         first_err_idx <= bit_cnt;
   end
`else
   assign first_err_idx = '0;
`endif

endmodule

// File: tb/tb_ff_stream_checker.sv
// Scoreboard bench for ff_stream_checker: stimulus pushes expectations, monitors pop and compare.
`timescale 1ns/1ps
module tb_ff_stream_checker;

   localparam int unsigned NB  = 64;
   localparam int unsigned ME  = 4;
   localparam int unsigned NB2 = 16;

   typedef struct packed {
      logic [1:0]  st;
      logic [31:0] bc;
      logic [15:0] ec;
      logic        ps;
      logic        fl;
      logic [31:0] fe;
      logic        de;
   } exp_t;

   typedef struct {
      string nm;
      exp_t  v;
   } ent_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic start = 1'b0, q_valid = 1'b0, q_in = 1'b0, probe = 1'b0;
   logic start2 = 1'b0, q_valid2 = 1'b0, q_in2 = 1'b0;

   logic        d_exp, pass, fail;
   logic [1:0]  state;
   logic [31:0] bit_cnt, first_err_idx;
   logic [15:0] err_cnt;

   logic        d_exp2, pass2, fail2;
   logic [1:0]  state2;
   logic [31:0] bit_cnt2, first_err_idx2;
   logic [1:0]  err_cnt2;

   ent_t sb[$];
   ent_t sb2[$];
   int   vectors = 0;
   int   miscompares = 0;
   logic stream [0:NB+1];
   logic fire;
   logic [1:0] prev_st2 = 2'd0;

   always #5 clk = ~clk;

   ff_stream_checker #(
      .NUM_BITS (NB),
      .MAX_ERR  (ME),
      .ERR_W    (16)
   ) dut (
      .clk (clk), .rst_n (rst_n), .start (start), .q_valid (q_valid), .q_in (q_in),
      .d_exp (d_exp), .state (state), .bit_cnt (bit_cnt), .err_cnt (err_cnt),
      .pass (pass), .fail (fail), .first_err_idx (first_err_idx)
   );

   ff_stream_checker #(
      .NUM_BITS (NB2),
      .MAX_ERR  (0),
      .ERR_W    (2)
   ) dut2 (
      .clk (clk), .rst_n (rst_n), .start (start2), .q_valid (q_valid2), .q_in (q_in2),
      .d_exp (d_exp2), .state (state2), .bit_cnt (bit_cnt2), .err_cnt (err_cnt2),
      .pass (pass2), .fail (fail2), .first_err_idx (first_err_idx2)
   );

   task automatic check(input string nm, input exp_t a, input exp_t e);
      vectors++;
      if (a !== e) begin
         miscompares++;
         $display("FAIL %s: got st=%0d bc=%0d ec=%0d pass=%0b fail=%0b fei=%0d d=%0b, want st=%0d bc=%0d ec=%0d pass=%0b fail=%0b fei=%0d d=%0b",
                  nm, a.st, a.bc, a.ec, a.ps, a.fl, a.fe, a.de, e.st, e.bc, e.ec, e.ps, e.fl, e.fe, e.de);
      end
   endtask

   // Monitor for the main instance: any edge where start/q_valid/probe was sampled.
   initial forever begin
      ent_t e;
      exp_t a;
      @(posedge clk);
      fire = q_valid | start | probe;
      #1;
      if (fire && sb.size() != 0) begin
         e = sb.pop_front();
         a = '{st: state, bc: bit_cnt, ec: err_cnt, ps: pass, fl: fail, fe: first_err_idx, de: d_exp};
         check(e.nm, a, e.v);
      end
   end

   // Monitor for the narrow-counter instance: checks when it reports DONE.
   initial forever begin
      ent_t e;
      exp_t a;
      @(posedge clk);
      #1;
      if (state2 == 2'd3 && prev_st2 != 2'd3 && sb2.size() != 0) begin
         e = sb2.pop_front();
         a = '{st: state2, bc: bit_cnt2, ec: {14'd0, err_cnt2}, ps: pass2, fl: fail2, fe: first_err_idx2, de: d_exp2};
         check(e.nm, a, e.v);
      end
      prev_st2 = state2;
   end

   task automatic push(input string nm, input exp_t v);
      ent_t e;
      e.nm = nm;
      e.v  = v;
      sb.push_back(e);
   endtask

   // Called at a negedge; returns at a negedge.
   task automatic strobe(input logic qi, input int gap);
      q_valid = 1'b1;
      q_in    = qi;
      @(negedge clk);
      q_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic reset_check(input string nm);
      rst_n = 1'b0;
      probe = 1'b1;
      push(nm, '0);
      @(negedge clk);
      probe = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic run(input string nm, input int flip, input bit zero, input int gap, input int rst_at);
      exp_t e;
      logic qi;
      logic m;
      int   k;
      bit   done;
      e = '0;
      qi = 1'b0;
      e.st = 2'd1;
      e.de = stream[0];
      push({nm, "_start"}, e);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      e.st = 2'd2;
      e.de = stream[1];
      push({nm, "_prime"}, e);
      strobe(~stream[0], gap);
      done = 1'b0;
      k = 0;
      while (!done) begin
         if (k == rst_at) begin
            reset_check({nm, "_midreset"});
            return;
         end
         qi = zero ? 1'b0 : (stream[k] ^ (k == flip));
         m  = (qi != stream[k]);
`ifdef FF_CHECKER_ERR_LOG_EN
         if (m && e.ec == 16'd0) e.fe = 32'(k);
`endif
         if (m && e.ec != 16'hFFFF) e.ec = e.ec + 16'd1;
         e.bc = 32'(k + 1);
         e.de = stream[k+2];
         if (k + 1 == NB || (ME != 0 && m && e.ec == 16'(ME))) begin
            done = 1'b1;
            e.st = 2'd3;
            e.ps = (e.ec == 16'd0);
            e.fl = (e.ec != 16'd0);
         end
         push($sformatf("%s_bit%0d", nm, k), e);
         strobe(qi, gap);
         k++;
      end
      push({nm, "_hold"}, e);
      strobe(~qi, 0);
   endtask

   initial begin
      logic [31:0] c;
      ent_t e2;
      c = 32'd3;
      for (int i = 0; i < NB + 2; i++) begin
         c = c * 32'd7;
         stream[i] = c[0] ^ 1'b0 ? ((c / 32'd11) % 2 == 1) : ((c / 32'd11) % 2 == 1);
      end
      #1 rst_n = 1'b0;
      @(negedge clk);
      reset_check("reset");

      run("golden", -1, 1'b0, 0, -1);
      run("flip5",   5, 1'b0, 0, -1);
      run("zero",   -1, 1'b1, 0, -1);
      run("gap",    -1, 1'b0, 2, -1);
      run("rst",    -1, 1'b0, 0, 20);
      run("postrst", -1, 1'b0, 0, -1);

      // Narrow counter, no abort, every bit inverted: err saturates at 3.
      e2.nm = "sat";
      e2.v  = '{st: 2'd3, bc: 32'(NB2), ec: 16'd3, ps: 1'b0, fl: 1'b1, fe: 32'd0, de: stream[NB2+1]};
      sb2.push_back(e2);
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      q_valid2 = 1'b1;
      q_in2 = stream[0];
      @(negedge clk);
      for (int k = 0; k < NB2; k++) begin
         q_in2 = ~stream[k];
         @(negedge clk);
      end
      q_valid2 = 1'b0;
      repeat (4) @(negedge clk);

      vectors++;
      if (sb.size() != 0 || sb2.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d/%0d pending expectations, want 0/0", sb.size(), sb2.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200us;
      $display("FAIL watchdog: got no completion by 200us, want finish");
      $fatal(1, "timeout");
   end

endmodule
